spi_cfg_sequencer: RTL and testbench

//   SPI configuration master for the decimal counter's spi_writer port. Serialises 8-bit

---
 rtl/spi_cfg_sequencer.sv | 141 ++++++++++++++
 tb/tb_spi_cfg_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_sequencer.sv
// SPI config master: serialises host writes or overflow-triggered preset reloads onto {cs_n, sclk, mosi}.
// Grant to SETUP in 1 cycle, GAP after (2*DATA_W+2)*DIV cycles; req_ready low while busy or a reload is pending.
module spi_cfg_sequencer #(
   parameter int DATA_W = 8,
   parameter int DIV    = 1,
   parameter int GAP_PH = 3
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              req_valid,
   input  logic [DATA_W-1:0] req_data,
   output logic              req_ready,
   input  logic              ovf_in,
   input  logic              reload_en,
   input  logic [DATA_W-1:0] reload_data,
   output logic [2:0]        spi,
   output logic              busy,
   output logic              done,
   output logic              src_reload,
   output logic              ovf_dropped
);
   localparam int PH_MAX = GAP_PH * DIV;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int BIT_W  = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD, S_GAP} state_t;

   state_t            state_q;
   logic [DATA_W-1:0] shift_q;
   logic [PH_W-1:0]   ph_q;
   logic [BIT_W-1:0]  bit_q;
   logic              ovf_q;
   logic              pend_q;
   logic [2:0]        spi_q;
   logic              busy_q;
   logic              done_q;
   logic              src_q;
   logic              drop_q;
   logic              ovf_edge;
   logic              ph_end;

   assign ovf_edge  = ovf_in & ~ovf_q;
   assign ph_end    = (state_q == S_GAP) ? (ph_q == PH_W'(PH_MAX - 1)) : (ph_q == PH_W'(DIV - 1));
   assign req_ready = (state_q == S_IDLE) & ~pend_q & RST_N;

   assign spi         = spi_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign src_reload  = src_q;
   assign ovf_dropped = drop_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         ph_q    <= '0;
         bit_q   <= '0;
         ovf_q   <= 1'b0;
         pend_q  <= 1'b0;
         spi_q   <= 3'b111;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         src_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         ovf_q  <= ovf_in;
         done_q <= 1'b0;
         // A second edge before the first reload is granted merges into it.
         if (ovf_edge && pend_q)
            drop_q <= 1'b1;
         if (ovf_edge && reload_en && !pend_q)
            pend_q <= 1'b1;
         ph_q <= ph_end ? '0 : ph_q + PH_W'(1);

         case (state_q)
            S_IDLE: begin
               ph_q <= '0;
               if (pend_q) begin
                  pend_q  <= 1'b0;
                  shift_q <= reload_data;
                  src_q   <= 1'b1;
                  state_q <= S_SETUP;
                  spi_q   <= 3'b011;
                  busy_q  <= 1'b1;
               end else if (req_valid) begin
                  shift_q <= req_data;
                  src_q   <= 1'b0;
                  state_q <= S_SETUP;
                  spi_q   <= 3'b011;
                  busy_q  <= 1'b1;
               end
            end
            S_SETUP: begin
               if (ph_end) begin
                  bit_q   <= '0;
                  state_q <= S_LOW;
                  spi_q   <= {2'b00, shift_q[DATA_W-1]};
               end
            end
            S_LOW: begin
               if (ph_end) begin
                  state_q <= S_HIGH;
                  spi_q   <= {2'b01, shift_q[DATA_W-1]};
               end
            end
            S_HIGH: begin
               if (ph_end) begin
                  shift_q <= shift_q << 1;
                  bit_q   <= bit_q + BIT_W'(1);
                  if (bit_q == BIT_W'(DATA_W - 1)) begin
                     state_q <= S_HOLD;
                     spi_q   <= 3'b011;
                  end else begin
                     // mosi takes the next bit only as sclk falls.
                     state_q <= S_LOW;
                     spi_q   <= {2'b00, shift_q[DATA_W-2]};
                  end
               end
            end
            S_HOLD: begin
               if (ph_end) begin
                  state_q <= S_GAP;
                  spi_q   <= 3'b111;
                  done_q  <= 1'b1;
               end
            end
            S_GAP: begin
               if (ph_end) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               spi_q   <= 3'b111;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer: DIV=1 instance for most steps, DIV=2 instance for the slow-clock frame.
module tb_spi_cfg_sequencer;
   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;

   logic       req_valid1 = 1'b0;
   logic [7:0] req_data1 = 8'h00;
   logic       req_ready1;
   logic       ovf_in1 = 1'b0;
   logic       reload_en1 = 1'b0;
   logic [7:0] reload_data1 = 8'h00;
   logic [2:0] spi1;
   logic       busy1, done1, src1, drop1;

   logic       req_valid2 = 1'b0;
   logic [7:0] req_data2 = 8'h00;
   logic       req_ready2;
   logic       ovf_in2 = 1'b0;
   logic       reload_en2 = 1'b0;
   logic [7:0] reload_data2 = 8'h00;
   logic [2:0] spi2;
   logic       busy2, done2, src2, drop2;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   spi_cfg_sequencer #(.DATA_W(8), .DIV(1), .GAP_PH(3)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid1), .req_data(req_data1), .req_ready(req_ready1),
      .ovf_in(ovf_in1), .reload_en(reload_en1), .reload_data(reload_data1), .spi(spi1),
      .busy(busy1), .done(done1), .src_reload(src1), .ovf_dropped(drop1));

   spi_cfg_sequencer #(.DATA_W(8), .DIV(2), .GAP_PH(3)) dut2 (
      .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
      .ovf_in(ovf_in2), .reload_en(reload_en2), .reload_data(reload_data2), .spi(spi2),
      .busy(busy2), .done(done2), .src_reload(src2), .ovf_dropped(drop2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with dut1 idle; returns at the negedge showing SETUP.
   task automatic host_write(input logic [7:0] d, input string tag);
      req_valid1 = 1'b1;
      req_data1  = d;
      chk({tag, "_ready"}, 32'(req_ready1), 32'd1);
      @(negedge CLK);
      req_valid1 = 1'b0;
   endtask

   // Called at the negedge of the first SETUP cycle; returns at the last GAP cycle.
   task automatic expect_frame(input bit sel, input logic [7:0] d, input int div,
                               input logic src_exp, input string tag);
      logic [2:0] exp_q[$];
      exp_q = {};
      repeat (div) exp_q.push_back(3'b011);
      for (int b = 7; b >= 0; b--) begin
         repeat (div) exp_q.push_back({2'b00, d[b]});
         repeat (div) exp_q.push_back({2'b01, d[b]});
      end
      repeat (div) exp_q.push_back(3'b011);
      repeat (3 * div) exp_q.push_back(3'b111);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) @(negedge CLK);
         chk($sformatf("%s_spi%0d", tag, i), 32'(sel ? spi2 : spi1), 32'(exp_q[i]));
         chk($sformatf("%s_busy%0d", tag, i), 32'(sel ? busy2 : busy1), 32'd1);
         chk($sformatf("%s_done%0d", tag, i), 32'(sel ? done2 : done1), 32'(i == 18 * div));
      end
      chk({tag, "_src"}, 32'(sel ? src2 : src1), 32'(src_exp));
   endtask

   task automatic wait_new_frame(input string tag);
      int n;
      n = 0;
      while (busy1 !== 1'b0 && n < 100) begin @(negedge CLK); n++; end
      while (busy1 !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
      chk({tag, "_timeout"}, 32'(n < 100), 32'd1);
   endtask

   logic [2:0] t1_spi [21] = '{3'd3, 3'd0, 3'd2, 3'd0, 3'd2, 3'd0, 3'd2, 3'd1, 3'd3, 3'd0, 3'd2,
                               3'd1, 3'd3, 3'd0, 3'd2, 3'd1, 3'd3, 3'd3, 3'd7, 3'd7, 3'd7};

   initial begin
      logic seen;

      // Reset state
      repeat (2) @(negedge CLK);
      chk("rst_spi", 32'(spi1), 32'h7);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_done", 32'(done1), 32'd0);
      chk("rst_src", 32'(src1), 32'd0);
      chk("rst_drop", 32'(drop1), 32'd0);
      chk("rst_ready", 32'(req_ready1), 32'd0);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("idle_ready", 32'(req_ready1), 32'd1);

      // 1: host 0x15, DIV=1, against the literal waveform
      host_write(8'h15, "t1");
      for (int i = 0; i < 21; i++) begin
         if (i > 0) @(negedge CLK);
         chk($sformatf("t1_spi%0d", i), 32'(spi1), 32'(t1_spi[i]));
         chk($sformatf("t1_done%0d", i), 32'(done1), 32'(i == 18));
      end
      chk("t1_src", 32'(src1), 32'd0);
      @(negedge CLK);
      chk("t1_idle", 32'(busy1), 32'd0);

      // 2: host 0xAA on the DIV=2 instance, 42 busy cycles
      req_valid2 = 1'b1;
      req_data2  = 8'hAA;
      chk("t2_ready", 32'(req_ready2), 32'd1);
      @(negedge CLK);
      req_valid2 = 1'b0;
      expect_frame(1'b1, 8'hAA, 2, 1'b0, "t2");
      @(negedge CLK);
      chk("t2_idle", 32'(busy2), 32'd0);

      // 3: pending reload beats a waiting host request
      reload_en1   = 1'b1;
      reload_data1 = 8'h2A;
      ovf_in1      = 1'b1;
      @(negedge CLK);
      req_valid1 = 1'b1;
      req_data1  = 8'h3F;
      chk("t3_ready_blocked", 32'(req_ready1), 32'd0);
      @(negedge CLK);
      reload_data1 = 8'h00;
      expect_frame(1'b0, 8'h2A, 1, 1'b1, "t3r");
      @(negedge CLK);
      chk("t3_host_ready", 32'(req_ready1), 32'd1);
      @(negedge CLK);
      req_valid1 = 1'b0;
      ovf_in1    = 1'b0;
      expect_frame(1'b0, 8'h3F, 1, 1'b0, "t3h");
      @(negedge CLK);

      // 4: two overflow edges during one host frame -> one reload, sticky drop flag
      host_write(8'h11, "t4");
      ovf_in1 = 1'b1;
      @(negedge CLK);
      ovf_in1 = 1'b0;
      reload_data1 = 8'h55;
      @(negedge CLK);
      ovf_in1 = 1'b1;
      @(negedge CLK);
      ovf_in1 = 1'b0;
      chk("t4_drop_set", 32'(drop1), 32'd1);
      wait_new_frame("t4");
      expect_frame(1'b0, 8'h55, 1, 1'b1, "t4r");
      seen = 1'b0;
      repeat (6) begin
         @(negedge CLK);
         if (busy1 !== 1'b0) seen = 1'b1;
      end
      chk("t4_no_second_reload", 32'(seen), 32'd0);
      chk("t4_drop_sticky", 32'(drop1), 32'd1);

      // 5: reset mid-frame after the third bit
      host_write(8'hC3, "t5");
      repeat (7) @(negedge CLK);
      RST_N = 1'b0;
      @(negedge CLK);
      chk("t5_spi", 32'(spi1), 32'h7);
      chk("t5_busy", 32'(busy1), 32'd0);
      chk("t5_done", 32'(done1), 32'd0);
      chk("t5_drop_clr", 32'(drop1), 32'd0);
      chk("t5_ready_in_rst", 32'(req_ready1), 32'd0);
      RST_N = 1'b1;
      seen = 1'b0;
      repeat (25) begin
         @(negedge CLK);
         if (done1 !== 1'b0 || busy1 !== 1'b0) seen = 1'b1;
      end
      chk("t5_abandoned", 32'(seen), 32'd0);
      host_write(8'h5A, "t5b");
      expect_frame(1'b0, 8'h5A, 1, 1'b0, "t5f");
      @(negedge CLK);

      // 6: overflow ignored while reload disabled
      reload_en1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ovf_in1 = ~ovf_in1;
         @(negedge CLK);
         chk($sformatf("t6_ready%0d", i), 32'(req_ready1), 32'd1);
         chk($sformatf("t6_busy%0d", i), 32'(busy1), 32'd0);
      end
      @(negedge CLK);
      chk("t6_final_busy", 32'(busy1), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
